// File: rtl/branch_update_scheduler.sv
// Purpose : sequences the branch prediction tables (clear sweep, lookup, update drain) and owns speculative global history.
// Latency : lookup path is combinational; a resolved branch reaches tbl_we no earlier than the cycle after it is accepted.
// Backpress: resolve_ready = !full (held low in reset); drain is paused while sweeping, pushes on a full queue are refused.
//
// Ports:
//   clk, rst                     clock and synchronous active-low reset
//   fetch_valid/fetch_pc         lookup request from fetch
//   pred_taken/pred_history      prediction and history returned to fetch
//   resolve_*                    resolved branch from execute (valid/ready)
//   flush_req, busy              table clear request and sweep-in-progress flag
//   tbl_pc/tbl_prev_history      lookup side of the tables; tbl_evict clears entry tbl_pc
//   tbl_prediction               table prediction bit
//   tbl_we/tbl_old_pc/tbl_update_history/tbl_taken   update side of the tables
module branch_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int PC_WIDTH   = 10,
    parameter int HIST_WIDTH = 3,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  pred_taken,
    output logic [HIST_WIDTH-1:0] pred_history,
    input  logic                  resolve_valid,
    output logic                  resolve_ready,
    input  logic [PC_WIDTH-1:0]   resolve_pc,
    input  logic                  resolve_taken,
    input  logic [HIST_WIDTH-1:0] resolve_history,
    input  logic                  resolve_mispredict,
    input  logic                  flush_req,
    output logic                  busy,
    output logic [PC_WIDTH-1:0]   tbl_pc,
    output logic [HIST_WIDTH-1:0] tbl_prev_history,
    input  logic                  tbl_prediction,
    output logic                  tbl_evict,
    output logic                  tbl_we,
    output logic [PC_WIDTH-1:0]   tbl_old_pc,
    output logic [HIST_WIDTH-1:0] tbl_update_history,
    output logic                  tbl_taken
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {SWEEP, RUN} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic                  taken;
        logic [HIST_WIDTH-1:0] hist;
    } entry_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  sweep_idx_q, sweep_idx_d;
    logic [HIST_WIDTH-1:0] hist_q, hist_d;

    entry_t                fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic   in_run;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;
    entry_t new_entry;

    // Outputs are qualified with rst so that the reset values appear while
    // rst is low, even before the first reset edge has loaded the registers.
    assign in_run        = rst && (state_q == RUN);
    assign full          = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty         = (count_q == '0);
    assign resolve_ready = rst && !full;
    assign push          = resolve_valid && resolve_ready;
    assign pop           = in_run && !empty;
    assign head          = fifo_q[rd_ptr_q];
    assign new_entry     = '{pc: resolve_pc, taken: resolve_taken, hist: resolve_history};

    assign busy             = !in_run;
    assign tbl_evict        = !in_run;
    assign tbl_pc           = in_run ? fetch_pc : (rst ? PC_WIDTH'(sweep_idx_q) : '0);
    assign pred_history     = rst ? hist_q : '0;
    assign tbl_prev_history = pred_history;
    assign pred_taken       = in_run && tbl_prediction;

    assign tbl_we             = pop;
    assign tbl_old_pc         = pop ? head.pc   : '0;
    assign tbl_update_history = pop ? head.hist : '0;
    assign tbl_taken          = pop ? head.taken : 1'b0;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        hist_d      = hist_q;

        if (state_q == SWEEP) begin
            sweep_idx_d = sweep_idx_q + IDX_WIDTH'(1);
            if (sweep_idx_q == {IDX_WIDTH{1'b1}}) begin
                state_d = RUN;
            end
        end

        // A mispredict repairs history from the lookup-time snapshot and
        // overrides any speculative shift from fetch in the same cycle.
        if (push && resolve_mispredict) begin
            hist_d = {resolve_history[HIST_WIDTH-2:0], resolve_taken};
        end else if (fetch_valid && in_run) begin
            hist_d = {hist_q[HIST_WIDTH-2:0], pred_taken};
        end

        if (flush_req) begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
            hist_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            hist_q      <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            hist_q      <= hist_d;
        end
    end

    // Flush empties the queue through the pointers; a push in the same cycle
    // lands in storage but is never made visible.
    always_ff @(posedge clk) begin
        if (!rst || flush_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
- Controller that sequences the 16-entry branch prediction tables: owns the 3-bit speculative global history and drives the tables' lookup-side pc/history.
- Buffers resolved-branch outcomes from execute in a small FIFO and drains them into the tables at one write per cycle.
- Runs the table-clear sweep after reset and on flush.
- Sits between fetch, execute and the prediction tables.

Parameters:
- FIFO_DEPTH, 4, resolve-queue entries (power of 2, >=2)
- PC_WIDTH, 10, branch address width
- HIST_WIDTH, 3, global history width
- IDX_WIDTH, 4, table index width (tables = 1<<IDX_WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- fetch_valid  in  1  fetch is looking up a branch this cycle
- fetch_pc  in  PC_WIDTH  branch address being looked up
- pred_taken  out  1  prediction returned to fetch
- pred_history  out  HIST_WIDTH  history used for this lookup (fetch carries it to execute)
- resolve_valid  in  1  execute presents a resolved branch
- resolve_ready  out  1  queue can accept (= not full)
- resolve_pc  in  PC_WIDTH  resolved branch address
- resolve_taken  in  1  actual outcome
- resolve_history  in  HIST_WIDTH  history snapshot from lookup time
- resolve_mispredict  in  1  prediction was wrong
- flush_req  in  1  request full table clear
- busy  out  1  high while SWEEP active
- tbl_pc  out  PC_WIDTH  table lookup pc
- tbl_prev_history  out  HIST_WIDTH  table lookup history
- tbl_prediction  in  1  table prediction bit
- tbl_evict  out  1  clear entry selected by tbl_pc
- tbl_we  out  1  table update strobe
- tbl_old_pc  out  PC_WIDTH  update address
- tbl_update_history  out  HIST_WIDTH  update history
- tbl_taken  out  1  update outcome

Behaviour:
- FSM states SWEEP, RUN.
  - rst low: state=SWEEP, sweep_idx=0, FIFO empty, spec_history=0.
  - SWEEP: tbl_evict=1, tbl_pc=zero-extended sweep_idx, sweep_idx++ each cycle; after index 15 is driven -> RUN next cycle. A full sweep is exactly 16 cycles.
  - RUN: tbl_evict=0, tbl_pc=fetch_pc.
- flush_req (either state): next cycle state=SWEEP, sweep_idx=0, FIFO emptied, spec_history=0. flush_req during SWEEP restarts at index 0. Any resolve pushed in the flush cycle is discarded.
- busy = (state==SWEEP).
- Prediction path, combinational:
  - tbl_prev_history = pred_history = spec_history.
  - pred_taken = tbl_prediction in RUN, 0 in SWEEP.
- History update, priority order:
  - Accepted resolve with resolve_mispredict=1: spec_history <= {resolve_history[HIST_WIDTH-2:0], resolve_taken}.
  - Else fetch_valid in RUN: spec_history <= {spec_history[HIST_WIDTH-2:0], pred_taken}.
  - Else hold. No shift in SWEEP.
- Resolve queue:
  - Push when resolve_valid && resolve_ready; resolve_ready = !full, combinational; pushes when full are ignored.
  - Entry = {pc, taken, history}; the mispredict flag is not stored.
  - Push and pop in the same cycle are allowed whenever not full; count is unchanged.
- Drain:
  - tbl_we = (state==RUN) && !empty; tbl_old_pc, tbl_update_history, tbl_taken = head entry; pop when tbl_we.
  - No same-cycle bypass: a branch accepted in cycle N writes no earlier than cycle N+1.
  - Drain is paused in SWEEP; tbl_we=0 and the tbl_old_pc/history/taken outputs =0.
- Reset values: pred_taken=0, pred_history=0, resolve_ready=0, busy=1, tbl_evict=1, tbl_pc=0, tbl_we=0, all tbl update outputs 0. resolve_ready is held 0 during reset and 1 after reset, FIFO empty.
- Reset mid-operation discards all queued updates.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Test Plan:
- Release rst -> busy=1 and tbl_evict=1 with tbl_pc=0..15 on 16 consecutive cycles, then busy=0, tbl_evict=0, tbl_pc follows fetch_pc.
- In RUN, resolve pc=0x2A5, taken=1, history=3'b101 in cycle N -> tbl_we=1 in N+1 with tbl_old_pc=0x2A5, tbl_update_history=3'b101, tbl_taken=1, then tbl_we=0.
- Hold tbl_prediction=1 with fetch_valid for 3 cycles from history 0 -> pred_history 000, 001, 011, then 111.
- Same cycle fetch_valid=1 and mispredict resolve (history=3'b010, taken=0) -> spec_history=3'b100; fetch shift ignored.
- Assert flush_req, then push 6 resolves back-to-back during SWEEP -> first 4 accepted, resolve_ready=0 for the last 2. After the sweep ends, 4 tbl_we pulses occur in FIFO order. Separately, flush_req mid-sweep at index 7 -> tbl_pc restarts at 0.
- Pull rst low with 3 queued entries -> no tbl_we afterwards, spec_history=0, new 16-cycle sweep.
